// File: rtl/mem_arbiter_if.sv
// Handshake bundle between the fetch and load/store requesters, the arbiter, and the data memory.
// The arbiter uses the slave modport; the requester/memory environment uses the master modport.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;

  logic              ls_req;
  logic              ls_we;
  logic [ADDR_W-1:0] ls_addr;
  logic [DATA_W-1:0] ls_wdata;
  logic              ls_gnt;
  logic              ls_done;
  logic [DATA_W-1:0] ls_rdata;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ren;
  logic              mem_wen;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, ls_gnt, ls_done, ls_rdata,
    input  mem_addr, mem_wdata, mem_ren, mem_wen
  );

  modport slave (
    input  if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, ls_gnt, ls_done, ls_rdata,
    output mem_addr, mem_wdata, mem_ren, mem_wen
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter/sequencer serialising fetch and load/store accesses onto a
// single-port memory, using a fixed IDLE -> ACCESS -> RESP transaction.
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.slave  bus,
  output logic          busy
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  state_t            state_r;
  logic              owner_r;       // 0 = fetch, 1 = load/store
  logic              last_owner_r;
  logic [ADDR_W-1:0] addr_r;
  logic [DATA_W-1:0] wdata_r;
  logic              ren_r;
  logic              wen_r;
  logic              rvalid_r;
  logic              done_r;
  logic              if_gnt_s;
  logic              ls_gnt_s;

  // Grant decode: only in IDLE; on contention the requester that did not win last time goes first
  always_comb begin
    if_gnt_s = 1'b0;
    ls_gnt_s = 1'b0;
    if (state_r == ST_IDLE) begin
      if (bus.if_req && bus.ls_req) begin
        if_gnt_s = last_owner_r;
        ls_gnt_s = ~last_owner_r;
      end else begin
        if_gnt_s = bus.if_req;
        ls_gnt_s = bus.ls_req;
      end
    end else begin
      if_gnt_s = 1'b0;
      ls_gnt_s = 1'b0;
    end
  end

  // Transaction sequencer with registered memory controls and response pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      owner_r      <= 1'b0;
      last_owner_r <= 1'b1;
      addr_r       <= {ADDR_W{1'b0}};
      wdata_r      <= {DATA_W{1'b0}};
      ren_r        <= 1'b0;
      wen_r        <= 1'b0;
      rvalid_r     <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          rvalid_r <= 1'b0;
          done_r   <= 1'b0;
          if (if_gnt_s) begin
            owner_r      <= 1'b0;
            last_owner_r <= 1'b0;
            addr_r       <= bus.if_addr;
            wdata_r      <= {DATA_W{1'b0}};
            ren_r        <= 1'b1;
            wen_r        <= 1'b0;
            state_r      <= ST_ACCESS;
          end else if (ls_gnt_s) begin
            owner_r      <= 1'b1;
            last_owner_r <= 1'b1;
            addr_r       <= bus.ls_addr;
            wdata_r      <= bus.ls_we ? bus.ls_wdata : {DATA_W{1'b0}};
            ren_r        <= ~bus.ls_we;
            wen_r        <= bus.ls_we;
            state_r      <= ST_ACCESS;
          end else begin
            ren_r <= 1'b0;
            wen_r <= 1'b0;
          end
        end
        ST_ACCESS: begin
          // Memory samples on this edge; the response pulse lines up with its registered data
          ren_r    <= 1'b0;
          wen_r    <= 1'b0;
          rvalid_r <= ~owner_r;
          done_r   <= owner_r;
          state_r  <= ST_RESP;
        end
        ST_RESP: begin
          rvalid_r <= 1'b0;
          done_r   <= 1'b0;
          state_r  <= ST_IDLE;
        end
        default: begin
          ren_r    <= 1'b0;
          wen_r    <= 1'b0;
          rvalid_r <= 1'b0;
          done_r   <= 1'b0;
          state_r  <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.if_gnt    = if_gnt_s;
  assign bus.ls_gnt    = ls_gnt_s;
  assign bus.mem_addr  = addr_r;
  assign bus.mem_wdata = wdata_r;
  assign bus.mem_ren   = ren_r;
  assign bus.mem_wen   = wen_r;
  assign bus.if_rvalid = rvalid_r;
  assign bus.ls_done   = done_r;
  assign bus.if_rdata  = bus.mem_rdata;
  assign bus.ls_rdata  = bus.mem_rdata;
  assign busy          = (state_r != ST_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized and directed bench for mem_arbiter: a byte-array memory, a transaction-level
// reference model (round-robin rule, 3-cycle transaction timing, byte-array contents) and a checker.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic busy;

  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  // Environment memory: 256 bytes, wraps, registered read, synchronous write, reset clears
  logic [7:0]  tmem [256];
  logic        pre_we = 1'b0;
  logic [7:0]  pre_addr = 8'h0;
  logic [31:0] pre_data = 32'h0;

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) tmem[i] <= 8'h00;
      bus.mem_rdata <= 32'h0;
    end else begin
      if (pre_we) begin
        for (int k = 0; k < 4; k++) tmem[8'(pre_addr + 8'(k))] <= pre_data[8*k +: 8];
      end
      if (bus.mem_wen) begin
        for (int k = 0; k < 4; k++) tmem[8'(bus.mem_addr[7:0] + 8'(k))] <= bus.mem_wdata[8*k +: 8];
      end
      if (bus.mem_ren) begin
        for (int k = 0; k < 4; k++) bus.mem_rdata[8*k +: 8] <= tmem[8'(bus.mem_addr[7:0] + 8'(k))];
      end
    end
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Reference model state
  logic [7:0]  ref_mem [256];
  bit          if_pend, ls_pend, ls_w;
  logic [31:0] if_a, ls_a, ls_d;
  int          cnt;            // cycles left in current transaction: 2 = access, 1 = response
  bit          cur_who, cur_we, last;
  logic [31:0] cur_a, cur_d, exp_d;
  int          cyc;
  int          lg_who [64];
  int          lg_cyc [64];
  int          lg_n;
  bit          rnd_en, hold_en;

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    logic [31:0] r;
    for (int k = 0; k < 4; k++) r[8*k +: 8] = ref_mem[8'(a[7:0] + 8'(k))];
    return r;
  endfunction

  task automatic ref_wr(input logic [31:0] a, input logic [31:0] d);
    for (int k = 0; k < 4; k++) ref_mem[8'(a[7:0] + 8'(k))] = d[8*k +: 8];
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = $urandom;
    if ($urandom_range(0, 3) != 0) a[31:8] = 24'h0;
    return a;
  endfunction

  task automatic model_reset();
    if_pend = 1'b0;
    ls_pend = 1'b0;
    cnt     = 0;
    last    = 1'b1;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
  endtask

  task automatic drive();
    if (rnd_en) begin
      if (if_pend && cnt != 0 && $urandom_range(0, 7) == 0) if_pend = 1'b0;
      if (ls_pend && cnt != 0 && $urandom_range(0, 7) == 0) ls_pend = 1'b0;
      if (!if_pend && $urandom_range(0, 2) == 0) begin
        if_pend = 1'b1; if_a = rand_addr();
      end
      if (!ls_pend && $urandom_range(0, 2) == 0) begin
        ls_pend = 1'b1; ls_w = 1'($urandom_range(0, 1)); ls_a = rand_addr(); ls_d = $urandom;
      end
    end
    if (hold_en) begin
      if (!if_pend) begin if_pend = 1'b1; if_a = rand_addr(); end
      if (!ls_pend) begin
        ls_pend = 1'b1; ls_w = 1'($urandom_range(0, 1)); ls_a = rand_addr(); ls_d = $urandom;
      end
    end
    bus.if_req   = if_pend;
    bus.if_addr  = if_pend ? if_a : $urandom;
    bus.ls_req   = ls_pend;
    bus.ls_we    = ls_pend ? ls_w : 1'($urandom_range(0, 1));
    bus.ls_addr  = ls_pend ? ls_a : $urandom;
    bus.ls_wdata = ls_pend ? ls_d : $urandom;
  endtask

  task automatic check_update();
    bit eg_if, eg_ls;
    chk("busy", 32'(busy), 32'(cnt != 0));
    chk("mem_ren", 32'(bus.mem_ren), 32'(cnt == 2 && !cur_we));
    chk("mem_wen", 32'(bus.mem_wen), 32'(cnt == 2 && cur_we));
    if (cnt == 2) begin
      chk("mem_addr", bus.mem_addr, cur_a);
      chk("mem_wdata", bus.mem_wdata, cur_we ? cur_d : 32'h0);
    end
    chk("if_rvalid", 32'(bus.if_rvalid), 32'(cnt == 1 && !cur_who));
    chk("ls_done", 32'(bus.ls_done), 32'(cnt == 1 && cur_who));
    if (cnt == 1 && !cur_we) begin
      if (!cur_who) chk("if_rdata", bus.if_rdata, exp_d);
      else          chk("ls_rdata", bus.ls_rdata, exp_d);
    end
    eg_if = 1'b0;
    eg_ls = 1'b0;
    if (cnt == 0) begin
      if (if_pend && ls_pend) begin
        eg_if = last;
        eg_ls = !last;
      end else begin
        eg_if = if_pend;
        eg_ls = ls_pend;
      end
    end
    chk("if_gnt", 32'(bus.if_gnt), 32'(eg_if));
    chk("ls_gnt", 32'(bus.ls_gnt), 32'(eg_ls));
    chk("gnt_onehot", 32'(bus.if_gnt & bus.ls_gnt), 32'h0);
    if (eg_if || eg_ls) begin
      cur_who = eg_ls;
      if (eg_ls) begin
        cur_we = ls_w; cur_a = ls_a; cur_d = ls_d; ls_pend = 1'b0;
      end else begin
        cur_we = 1'b0; cur_a = if_a; cur_d = 32'h0; if_pend = 1'b0;
      end
      exp_d = ref_rd(cur_a);
      if (cur_we) ref_wr(cur_a, cur_d);
      last = cur_who;
      if (lg_n < 64) begin
        lg_who[lg_n] = int'(cur_who);
        lg_cyc[lg_n] = cyc;
        lg_n++;
      end
      cnt = 2;
    end else if (cnt != 0) begin
      cnt--;
    end
    cyc++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    drive();
    @(negedge clk);
    check_update();
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && (cnt != 0 || if_pend || ls_pend); i++) step();
    chk("drain_bound", 32'(cnt != 0 || if_pend || ls_pend), 32'h0);
  endtask

  task automatic do_reset(input int n);
    @(posedge clk);
    #1;
    reset = 1'b1;
    model_reset();
    drive();
    repeat (n) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #300000;
    $display("FAIL timeout: simulation bound reached");
    $fatal(1, "timeout");
  end

  initial begin
    int c0;
    rnd_en = 1'b0; hold_en = 1'b0; cyc = 0; lg_n = 0;
    if_a = 32'h0; ls_a = 32'h0; ls_d = 32'h0; ls_w = 1'b0;
    cur_who = 1'b0; cur_we = 1'b0; cur_a = 32'h0; cur_d = 32'h0; exp_d = 32'h0;
    model_reset();
    drive();
    do_reset(3);

    // Reset state
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_ren", 32'(bus.mem_ren), 32'h0);
    chk("rst_wen", 32'(bus.mem_wen), 32'h0);
    chk("rst_addr", bus.mem_addr, 32'h0);
    chk("rst_wdata", bus.mem_wdata, 32'h0);
    chk("rst_rvalid", 32'(bus.if_rvalid), 32'h0);
    chk("rst_done", 32'(bus.ls_done), 32'h0);

    // Idle window: nothing granted, no enables, not busy
    repeat (10) step();

    // Preload 0xDEADBEEF at 0x10, then a fetch
    @(posedge clk); #1;
    pre_we = 1'b1; pre_addr = 8'h10; pre_data = 32'hDEADBEEF;
    ref_wr(32'h10, 32'hDEADBEEF);
    @(posedge clk); #1;
    pre_we = 1'b0;
    if_pend = 1'b1; if_a = 32'h10;
    c0 = cyc; lg_n = 0;
    repeat (4) step();
    chk("fetch_gnt_cycle", 32'(lg_n == 1 && lg_cyc[0] == c0 && lg_who[0] == 0), 32'h1);
    chk("fetch_model_data", exp_d, 32'hDEADBEEF);

    // Store then load at 0x20
    ls_pend = 1'b1; ls_w = 1'b1; ls_a = 32'h20; ls_d = 32'h12345678;
    drain();
    chk("store_byte20", 32'(tmem[8'h20]), 32'h78);
    ls_pend = 1'b1; ls_w = 1'b0; ls_a = 32'h20;
    drain();
    chk("load_model_data", exp_d, 32'h12345678);

    // Contention after reset: IF, LS, IF, LS at 0, 3, 6, 9
    do_reset(2);
    hold_en = 1'b1;
    c0 = cyc; lg_n = 0;
    repeat (12) step();
    hold_en = 1'b0;
    chk("cont_count", 32'(lg_n), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk("cont_who", 32'(lg_who[i]), 32'(i % 2));
      chk("cont_cycle", 32'(lg_cyc[i] - c0), 32'(3 * i));
    end
    drain();

    // Reset during ACCESS of a store to 0x40
    do_reset(2);
    ls_pend = 1'b1; ls_w = 1'b1; ls_a = 32'h40; ls_d = 32'hAABBCCDD;
    step();
    chk("rst_acc_granted", 32'(cnt), 32'd2);
    @(posedge clk); #1;
    reset = 1'b1;
    bus.ls_req = 1'b0;
    @(negedge clk);
    chk("rst_acc_wen", 32'(bus.mem_wen), 32'h1);
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    drive();
    @(negedge clk);
    chk("rst_acc_no_done", 32'(bus.ls_done), 32'h0);
    chk("rst_acc_idle", 32'(busy), 32'h0);
    repeat (2) step();
    chk("rst_acc_mem40", 32'(tmem[8'h40]), 32'h0);
    // Contention afterwards: fetch first, then the load of 0x40 returns cleared contents
    if_pend = 1'b1; if_a = 32'h40;
    ls_pend = 1'b1; ls_w = 1'b0; ls_a = 32'h40;
    lg_n = 0;
    drain();
    chk("rst_acc_if_first", 32'(lg_n == 2 && lg_who[0] == 0 && lg_who[1] == 1), 32'h1);
    chk("rst_acc_load0", exp_d, 32'h0);

    // Fetch request raised and dropped while busy is never served
    ls_pend = 1'b1; ls_w = 1'b0; ls_a = 32'h30;
    lg_n = 0;
    step();
    if_pend = 1'b1; if_a = 32'h44;
    step();
    if_pend = 1'b0;
    repeat (5) step();
    chk("drop_no_txn", 32'(lg_n), 32'd1);

    // Randomized traffic
    rnd_en = 1'b1;
    repeat (400) step();
    rnd_en = 1'b0;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the single-port byte-addressed data memory.
- The memory has a 32-bit little-endian word port, registered read data and synchronous write.
- Requester 0 is instruction fetch (read-only). Requester 1 is load/store (read or write).
- Serialises accesses, drives memory ren/wen/addr/wdata, and returns read data or completion to the granted requester with a fixed 3-cycle transaction.

Parameters:
- ADDR_W, 32, width of byte addresses passed to memory.
- DATA_W, 32, width of data words.

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  synchronous, active-high reset.
- if_req  input  1  fetch request; held with if_addr until if_gnt.
- if_addr  input  ADDR_W  fetch byte address.
- if_gnt  output  1  fetch request accepted this cycle.
- if_rvalid  output  1  one-cycle pulse: if_rdata valid.
- if_rdata  output  DATA_W  fetch read data.
- ls_req  input  1  load/store request; held with ls_we/ls_addr/ls_wdata until ls_gnt.
- ls_we  input  1  1 = store, 0 = load.
- ls_addr  input  ADDR_W  load/store byte address.
- ls_wdata  input  DATA_W  store data.
- ls_gnt  output  1  load/store request accepted this cycle.
- ls_done  output  1  one-cycle pulse: load data valid or store committed.
- ls_rdata  output  DATA_W  load read data.
- mem_addr  output  ADDR_W  memory address.
- mem_wdata  output  DATA_W  memory write data.
- mem_ren  output  1  memory read enable.
- mem_wen  output  1  memory write enable.
- mem_rdata  input  DATA_W  memory registered read data.
- busy  output  1  high whenever state is not IDLE.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on port reset.
- Reset values: state = IDLE; mem_ren, mem_wen, if_rvalid, ls_done = 0; mem_addr, mem_wdata = 0; owner = 0; last_owner = 1 (fetch wins first contention); busy = 0.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - Gnt is combinational and asserted only in IDLE; at most one of if_gnt/ls_gnt is high.
  - Only if_req: if_gnt = 1.
  - Only ls_req: ls_gnt = 1.
  - Both: round-robin, grant the requester that is not last_owner.
  - On the grant edge, register:
    - owner;
    - mem_addr;
    - mem_wdata (ls_wdata for store, else 0);
    - mem_ren = 1 (fetch or load) or mem_wen = 1 (store).
  - Also update last_owner = owner and go to ACCESS.
  - No request: stay in IDLE, outputs unchanged except enables = 0.
- ACCESS:
  - mem_ren/mem_wen are high for exactly this cycle; memory samples on the edge ending ACCESS.
  - On that edge: clear both enables and go to RESP.
- RESP:
  - mem_rdata holds the addressed word.
  - owner = fetch: if_rvalid = 1.
  - owner = load/store: ls_done = 1, for both load and store.
  - if_rdata and ls_rdata pass mem_rdata through combinationally; they are meaningful only while the matching valid/done is high.
  - Next state is IDLE; no grant is given in RESP.
- Timing:
  - Latency from grant edge to rvalid/done: 2 cycles.
  - Throughput: one transaction per 3 cycles.
  - A requester still holding req after its done is re-arbitrated in the following IDLE cycle.
- Address: passed unmodified; no alignment check. The memory wraps/assembles bytes as addr..addr+3.
- Requests dropped before grant are ignored. Request changes after grant do not affect the in-flight transaction.
- Reset mid-operation:
  - In ACCESS: the memory is reset on the same edge, so no write commits.
  - Any state: FSM returns to IDLE, no done/rvalid pulse is produced, and last_owner returns to 1.
- Simultaneous ls_req and if_req in consecutive IDLE windows alternate strictly: IF, LS, IF, LS...

Test Plan:
- Fetch read: memory preloaded so that word at address 0x10 = 0xDEADBEEF; if_req=1, if_addr=0x10 -> if_gnt in cycle 0, mem_ren=1 in cycle 1, if_rvalid=1 with if_rdata=0xDEADBEEF in cycle 2, busy=0 in cycle 3.
- Store then load: ls_we=1, ls_addr=0x20, ls_wdata=0x12345678, then load 0x20 -> ls_done on store's cycle 2; load returns ls_rdata=0x12345678. Byte 0x20 = 0x78.
- Contention after reset: if_req and ls_req both high and held -> grants IF, LS, IF, LS at cycles 0, 3, 6, 9. No cycle has both gnts high.
- Reset in ACCESS of store 0xAABBCCDD to 0x40 -> no ls_done; a later load of 0x40 returns the prior contents (0 after memory reset); next contention grants IF first.
- Idle/no request -> mem_ren=mem_wen=0, busy=0, no gnt for 10 cycles. if_req dropped before any grant -> no transaction.
